instr_prefetch: RTL and testbench

INSTR_PREFETCH -- requirements
Module: instr_prefetch

---
 rtl/instr_prefetch.sv | 128 ++++++++++++
 tb/tb_instr_prefetch.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : instr_prefetch
// Purpose  : Single-outstanding instruction fetch engine. It issues one read
//            at a time to instruction memory and pushes each returned
//            instruction into a downstream FIFO. A redirect re-points the
//            fetch stream, flushes the FIFO, and discards any response that
//            belongs to the old stream.
// Ports    : clk, reset_n             - clock, async active-low reset
//            fetch_en                 - permits new fetch requests
//            redirect_valid/_pc       - one-cycle fetch-stream change
//            mem_req/mem_addr/mem_gnt - memory request handshake
//            mem_rvalid/mem_rdata     - memory read response
//            fifo_full                - downstream FIFO full flag
//            fifo_wr_en/fifo_wr_data  - one-cycle push into the FIFO
//            fifo_flush               - discard buffered instructions
//            busy                     - engine not idle
// Revision : 1.0 - initial release
// ============================================================================
module instr_prefetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
    output logic                  fifo_flush,
    output logic                  busy
);

    // DROP: a request was granted but its response belongs to a stream that
    // has since been redirected, so it must be swallowed.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_nxt;
    logic                  w_push;

    // Redirect targets are word aligned; the two low bits are dropped.
    logic                  w_unused_lsbs;
    assign w_unused_lsbs = ^redirect_pc[1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_push      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // A redirect in IDLE only moves the pc; the request is
                // launched on a later cycle from the new address.
                if (!redirect_valid && fetch_en && !fifo_full) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    w_state_nxt = redirect_valid ? ST_DROP : ST_WAIT;
                end else if (redirect_valid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    w_state_nxt = ST_IDLE;
                    if (!redirect_valid) begin
                        w_push   = 1'b1;
                        w_pc_nxt = r_pc + ADDR_WIDTH'(4);
                    end
                end else if (redirect_valid) begin
                    w_state_nxt = ST_DROP;
                end
            end
            ST_DROP: begin
                if (mem_rvalid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Redirect wins over the sequential increment in every state.
        if (redirect_valid) begin
            w_pc_nxt = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        end
    end

    assign mem_req      = (r_state == ST_REQ);
    assign mem_addr     = r_pc;
    assign fifo_wr_en   = w_push;
    assign fifo_wr_data = w_push ? mem_rdata : '0;
    // Gated so the flush output stays quiet while the block is held in reset.
    assign fifo_flush   = redirect_valid & reset_n;
    assign busy         = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_instr_prefetch
// Purpose  : Self-checking bench for instr_prefetch. A transaction-level
//            reference (pending request / outstanding response / discard
//            flags plus a pc) predicts every output each cycle; directed
//            scenarios are followed by a randomized run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_prefetch;

    localparam int          AW       = 32;
    localparam int          DW       = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic          clk;
    logic          reset_n;
    logic          fetch_en;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          fifo_full;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_wr_data;
    logic          fifo_flush;
    logic          busy;

    instr_prefetch #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .fetch_en      (fetch_en),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .fifo_full     (fifo_full),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_wr_data  (fifo_wr_data),
        .fifo_flush    (fifo_flush),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: a request waiting for grant, a granted read awaiting its
    // response, whether that response is stale, and the fetch pointer.
    logic [31:0] m_pc;
    bit          m_req;
    bit          m_out;
    bit          m_disc;
    int          m_wait;

    // Bench memory behaviour for directed steps.
    int          mem_lat    = 2;
    int          gnt_stall  = 0;
    logic [31:0] mem_data   = 32'h0000_0013;

    // Observations from the latest step.
    logic        obs_req, obs_wr_en, obs_flush, obs_busy;
    logic [31:0] obs_addr;
    logic [31:0] push_addrs[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc      = RESET_PC;
        m_req     = 0;
        m_out     = 0;
        m_disc    = 0;
        m_wait    = 0;
        gnt_stall = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req"}, mem_req, 0);
        check({tag, "_mem_addr"}, mem_addr, RESET_PC);
        check({tag, "_wr_en"}, fifo_wr_en, 0);
        check({tag, "_wr_data"}, fifo_wr_data, 0);
        check({tag, "_flush"}, fifo_flush, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
    task automatic step(input bit fe, input bit ff, input bit gnt, input bit rv,
                        input logic [31:0] rdata, input bit rdr, input logic [31:0] rpc);
        bit e_push;
        fetch_en       = fe;
        fifo_full      = ff;
        mem_gnt        = gnt;
        mem_rvalid     = rv;
        mem_rdata      = rdata;
        redirect_valid = rdr;
        redirect_pc    = rpc;
        #2;
        e_push = m_out && !m_disc && rv && !rdr;
        obs_req   = mem_req;
        obs_addr  = mem_addr;
        obs_wr_en = fifo_wr_en;
        obs_flush = fifo_flush;
        obs_busy  = busy;
        check("mem_req", mem_req, m_req);
        check("mem_addr", mem_addr, m_pc);
        check("wr_en", fifo_wr_en, e_push);
        check("flush", fifo_flush, rdr);
        check("busy", busy, m_req || m_out);
        if (e_push) check("wr_data", fifo_wr_data, rdata);
        if (fifo_wr_en) push_addrs.push_back(mem_addr);
        @(posedge clk);
        #1;
        if (rdr)         m_pc = {rpc[31:2], 2'b00};
        else if (e_push) m_pc = m_pc + 32'd4;
        if (m_out) begin
            if (rv) begin
                m_out  = 0;
                m_disc = 0;
            end else begin
                if (rdr) m_disc = 1;
                m_wait++;
            end
        end else if (m_req) begin
            if (gnt) begin
                m_req  = 0;
                m_out  = 1;
                m_disc = rdr;
                m_wait = 1;
            end else if (rdr) begin
                m_req = 0;
            end
        end else if (!rdr && fe && !ff) begin
            m_req = 1;
        end
    endtask

    // Step with the bench memory answering: grant after gnt_stall cycles,
    // response mem_lat cycles after grant.
    task automatic auto_step(input bit fe, input bit ff, input bit rdr, input logic [31:0] rpc);
        bit g, r;
        g = m_req && (gnt_stall == 0);
        if (m_req && gnt_stall > 0) gnt_stall--;
        r = m_out && (m_wait >= mem_lat);
        step(fe, ff, g, r, mem_data, rdr, rpc);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (m_req || m_out); i++) auto_step(0, 0, 0, 32'h0);
        check("drain_busy", busy, 0);
    endtask

    initial begin
        bit          fe, ff, g, r, rdr;
        logic [31:0] rpc;

        reset_n = 0; fetch_en = 0; fifo_full = 0; mem_gnt = 0; mem_rvalid = 0;
        mem_rdata = 0; redirect_valid = 0; redirect_pc = 0;
        model_reset();
        #1;
        check_reset_outputs("por");
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1;

        // Streaming fetch: one push every four cycles at 0x0, 0x4, 0x8.
        mem_lat = 2; mem_data = 32'h0000_0013;
        push_addrs.delete();
        for (int i = 0; i < 12; i++) auto_step(1, 0, 0, 32'h0);
        check("stream_count", push_addrs.size(), 3);
        if (push_addrs.size() >= 3) begin
            check("stream_a0", push_addrs[0], 32'h0);
            check("stream_a1", push_addrs[1], 32'h4);
            check("stream_a2", push_addrs[2], 32'h8);
        end

        // Grant stall: request held stable at 0x4 for five cycles.
        auto_step(1, 0, 1, 32'h4);
        check("idle_redir_busy", obs_busy, 0);
        gnt_stall = 5;
        auto_step(1, 0, 0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            auto_step(1, 0, 0, 32'h0);
            check("stall_req", obs_req, 1);
            check("stall_addr", obs_addr, 32'h4);
            check("stall_push", obs_wr_en, 0);
        end
        drain();

        // Full FIFO holds off the request; release gives mem_req next cycle.
        for (int i = 0; i < 3; i++) begin
            auto_step(1, 1, 0, 32'h0);
            check("full_no_req", obs_req, 0);
        end
        auto_step(1, 0, 0, 32'h0);
        auto_step(1, 0, 0, 32'h0);
        check("full_release_req", obs_req, 1);
        drain();

        // Redirect in WAIT, response two cycles later is discarded.
        mem_lat = 3;
        auto_step(1, 0, 0, 32'h0);
        auto_step(1, 0, 0, 32'h0);
        auto_step(1, 0, 1, 32'h103);
        check("wait_redir_flush", obs_flush, 1);
        auto_step(0, 0, 0, 32'h0);
        check("drop_flush_low", obs_flush, 0);
        check("drop_busy", obs_busy, 1);
        auto_step(0, 0, 0, 32'h0);
        check("drop_no_push", obs_wr_en, 0);
        auto_step(1, 0, 0, 32'h0);
        auto_step(1, 0, 0, 32'h0);
        check("redir_req", obs_req, 1);
        check("redir_addr", obs_addr, 32'h100);
        drain();

        // Redirect coincident with the response.
        mem_lat = 2;
        auto_step(1, 0, 0, 32'h0);
        auto_step(1, 0, 0, 32'h0);
        auto_step(1, 0, 0, 32'h0);
        auto_step(1, 0, 1, 32'h200);
        check("coinc_no_push", obs_wr_en, 0);
        auto_step(0, 0, 0, 32'h0);
        check("coinc_idle", obs_busy, 0);
        check("coinc_pc", obs_addr, 32'h200);

        // Reset pulse during WAIT, then a late response.
        auto_step(1, 0, 0, 32'h0);
        auto_step(1, 0, 0, 32'h0);
        auto_step(1, 0, 0, 32'h0);
        reset_n = 0; mem_rvalid = 1; mem_rdata = 32'hdead_beef; mem_gnt = 0;
        redirect_valid = 0; fetch_en = 1; fifo_full = 0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        reset_n = 1;
        model_reset();
        step(1, 0, 0, 1, 32'hdead_beef, 0, 32'h0);
        check("late_rvalid_ignored", obs_wr_en, 0);
        auto_step(1, 0, 0, 32'h0);
        check("refetch_req", obs_req, 1);
        check("refetch_addr", obs_addr, RESET_PC);
        drain();

        // Randomized traffic, including stray responses outside WAIT/DROP.
        for (int i = 0; i < 1500; i++) begin
            fe  = ($urandom % 8) != 0;
            ff  = ($urandom % 4) == 0;
            rdr = ($urandom % 10) == 0;
            rpc = $urandom;
            g   = m_req ? (($urandom % 3) != 0) : (($urandom % 2) == 1);
            r   = m_out ? ((m_wait >= 3) || (($urandom % 2) == 1)) : (($urandom % 16) == 0);
            step(fe, ff, g, r, $urandom, rdr, rpc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
